// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath among NREQ requesters.
// Optional MUL_TIMEOUT_EN bounds RUN to MAX_ITER accumulate cycles and pulses err in DONE.
module mul_rr_scheduler #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel,
  output logic            ldA,
  output logic            ldB,
  output logic            clrP,
  output logic            ldP,
  output logic            decB,
  input  logic            eqz,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            err
);

  if (NREQ < 2 || NREQ > 8 || SELW != $clog2(NREQ) || MAX_ITER < 1) begin : g_cfg_err
    $error("mul_rr_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] sel_q;
  logic [NREQ-1:0] gnt_q;
  logic [SELW-1:0] idx_c;
  logic [SELW-1:0] win_c;
  logic            found_c;
  logic [SELW-1:0] ptr_next_c;

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(MAX_ITER + 1);
  logic [CNTW-1:0] iter_q;
  logic            err_q;
`endif

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    idx_c   = '0;
    win_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = SELW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && req[idx_c]) begin
        found_c = 1'b1;
        win_c   = idx_c;
      end
    end
  end

  assign ptr_next_c = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
`ifdef MUL_TIMEOUT_EN
      iter_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found_c) begin
            gnt_q   <= NREQ'(1) << win_c;
            sel_q   <= win_c;
            state_q <= S_LDA;
          end
        end
        S_LDA: state_q <= S_LDB;
        S_LDB: begin
          state_q <= S_RUN;
`ifdef MUL_TIMEOUT_EN
          iter_q  <= '0;
`endif
        end
        S_RUN: begin
`ifdef MUL_TIMEOUT_EN
          if (eqz) begin
            state_q <= S_DONE;
          end else if (iter_q == CNTW'(MAX_ITER - 1)) begin
            state_q <= S_DONE;
            err_q   <= 1'b1;
          end else begin
            iter_q  <= iter_q + CNTW'(1);
          end
`else
          if (eqz) state_q <= S_DONE;
`endif
        end
        S_DONE: begin
          ptr_q   <= ptr_next_c;
          gnt_q   <= '0;
          state_q <= S_IDLE;
`ifdef MUL_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; ldP/decB also gated by eqz.
  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign ldA  = (state_q == S_LDA);
  assign ldB  = (state_q == S_LDB);
  assign clrP = (state_q == S_LDB);
  assign ldP  = (state_q == S_RUN) && !eqz;
  assign decB = (state_q == S_RUN) && !eqz;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) ? gnt_q : '0;
`ifdef MUL_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: behavioural datapath plus a round-robin/latency reference model.
// Define MUL_TIMEOUT_EN on both files to exercise the timeout path.
module tb_mul_rr_scheduler;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned SELW     = 2;
  localparam int unsigned MAX_ITER = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel;
  logic            ldA, ldB, clrP, ldP, decB, eqz, busy, err;
  logic [NREQ-1:0] done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int m_ptr  = 0;

  logic [15:0] opA [NREQ];
  logic [15:0] opB [NREQ];
  logic [15:0] a_q = '0;
  logic [15:0] b_q = '0;
  logic [31:0] p_q = '0;
  bit          hold_eqz0 = 1'b0;

  mul_rr_scheduler #(.NREQ(NREQ), .SELW(SELW), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
    .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
    .eqz(eqz), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared datapath model: eqz is a pure function of the B register.
  assign eqz = hold_eqz0 ? 1'b0 : (b_q == 16'd0);
  always @(posedge clk) begin
    if (ldA) a_q <= opA[sel];
    if (ldB) b_q <= opB[sel];
    if (decB) b_q <= b_q - 16'd1;
    if (clrP) p_q <= '0;
    else if (ldP) p_q <= p_q + 32'(a_q);
  end

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Measures one operation from request to done; comparisons are made by the caller.
  task automatic observe_op(input bit drop, output logic [NREQ-1:0] g, output int s,
                            output int tg, output int td, output int nldp, output int nbusy,
                            output logic [NREQ-1:0] d, output logic e, output bit ok);
    ok = 0; g = '0; s = -1; tg = -1; td = -1; nldp = 0; nbusy = 0; d = '0; e = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (ldP) nldp++;
      if (tg < 0 && gnt != '0) begin
        g = gnt; s = int'(sel); tg = cyc;
        if (drop) req = '0;
      end
      if (done != '0) begin
        d = done; e = err; td = cyc; ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, sel, done, err, busy, ldA, ldB, clrP, ldP, decB} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b sel=%0d done=%b err=%b busy=%b ctl=%b%b%b%b%b exp all 0",
               gnt, sel, done, err, busy, ldA, ldB, clrP, ldP, decB);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b exp 0", busy);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    opA[0] = 16'd7; opB[0] = 16'd3;
    req = 4'b0001;
    observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
    req = '0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no done within budget"); end
    checks++;
    if (g !== 4'b0001 || s != 0) begin
      errors++; $display("FAIL single_gnt: got gnt=%b sel=%0d exp 0001/0", g, s);
    end
    checks++;
    if (nl != 3) begin errors++; $display("FAIL single_ldp: got %0d cycles exp 3", nl); end
    checks++;
    if (td - tg != 6 || d !== 4'b0001) begin
      errors++; $display("FAIL single_done: got lat=%0d done=%b exp 6/0001", td - tg, d);
    end
    checks++;
    if (nb != 7) begin errors++; $display("FAIL single_busy: got %0d cycles exp 7", nb); end
    @(negedge clk);
    checks++;
    if (p_q !== 32'd21 || busy !== 1'b0 || done !== '0) begin
      errors++; $display("FAIL single_after: got P=%0d busy=%b done=%b exp 21/0/0", p_q, busy, done);
    end
    m_ptr = 1;
  endtask

  task automatic test_bzero();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    opA[2] = 16'd9; opB[2] = 16'd0;
    req = 4'b0100;
    observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
    req = '0;
    checks++;
    if (!ok || nl != 0 || td - tg != 3 || d !== 4'b0100) begin
      errors++;
      $display("FAIL bzero_op: got ok=%0d ldp=%0d lat=%0d done=%b exp 1/0/3/0100", ok, nl, td - tg, d);
    end
    @(negedge clk);
    checks++;
    if (p_q !== 32'd0) begin errors++; $display("FAIL bzero_p: got %0d exp 0", p_q); end
    m_ptr = 3;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    int prev_td;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = 16'($urandom_range(0, 100)); opB[i] = 16'($urandom_range(0, 5));
    end
    prev_td = -1;
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
      checks++;
      if (!ok || s != exp_order[n] || g !== NREQ'(1) << exp_order[n]) begin
        errors++; $display("FAIL rr_order[%0d]: got sel=%0d gnt=%b exp %0d", n, s, g, exp_order[n]);
      end
      if (prev_td >= 0) begin
        checks++;
        if (tg - prev_td != 2) begin
          errors++; $display("FAIL rr_gap[%0d]: got %0d cycles done-to-grant exp 2", n, tg - prev_td);
        end
      end
      prev_td = td;
    end
    req = '0;
    @(negedge clk);
    m_ptr = 2;
  endtask

  task automatic test_priority();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    do_reset();
    opB[0] = 16'd2; opB[1] = 16'd1;
    req = 4'b0001;
    observe_op(1'b1, g, s, tg, td, nl, nb, d, e, ok);
    @(negedge clk);
    req = 4'b0011;
    observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
    checks++;
    if (!ok || g !== 4'b0010) begin errors++; $display("FAIL prio_first: got gnt=%b exp 0010", g); end
    observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin errors++; $display("FAIL prio_second: got gnt=%b exp 0001", g); end
    req = '0;
    @(negedge clk);
    m_ptr = 1;
  endtask

  task automatic test_reset_mid_run();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    int nrun; bit seen_done;
    do_reset();
    opA[1] = 16'd5; opB[1] = 16'd200;
    req = 4'b0010;
    nrun = 0;
    for (int t = 0; t < 300 && nrun < 10; t++) begin
      @(negedge clk);
      if (ldP) nrun++;
    end
    checks++;
    if (nrun != 10) begin errors++; $display("FAIL rst_run_reach: got %0d RUN cycles exp 10", nrun); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, sel, done, err, busy, ldA, ldB, clrP, ldP, decB} !== '0) begin
      errors++;
      $display("FAIL rst_async: got gnt=%b done=%b busy=%b ldP=%b decB=%b exp all 0", gnt, done, busy, ldP, decB);
    end
    req = '0;
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0) seen_done = 1;
    end
    rst = 1'b0;
    m_ptr = 0;
    opA[3] = 16'd3; opB[3] = 16'd2;
    req = 4'b1000;
    observe_op(1'b0, g, s, tg, td, nl, nb, d, e, ok);
    if (done != '0) seen_done = 1;
    checks++;
    if (seen_done && !ok) begin errors++; $display("FAIL rst_no_done: stray done pulse"); end
    checks++;
    if (!ok || s != pick(4'b1000, m_ptr) || d !== 4'b1000) begin
      errors++; $display("FAIL rst_rewin: got sel=%0d done=%b exp 3/1000", s, d);
    end
    req = '0;
    @(negedge clk);
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, d, r; int s, tg, td, nl, nb; logic e; bit ok, drop;
    int exp_w;
    logic [31:0] exp_p;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        opA[i] = 16'($urandom_range(0, 1000)); opB[i] = 16'($urandom_range(0, 12));
      end
      r = NREQ'($urandom_range(1, 15));
      drop = bit'($urandom_range(0, 1));
      exp_w = pick(r, m_ptr);
      exp_p = 32'(opA[exp_w]) * 32'(opB[exp_w]);
      req = r;
      observe_op(drop, g, s, tg, td, nl, nb, d, e, ok);
      checks++;
      if (!ok || s != exp_w || g !== NREQ'(1) << exp_w || d !== g || e !== 1'b0) begin
        errors++;
        $display("FAIL rand_grant[%0d]: req=%b got sel=%0d gnt=%b done=%b err=%b exp sel=%0d", n, r, s, g, d, e, exp_w);
      end
      checks++;
      if (td - tg != 3 + int'(opB[exp_w]) || nl != int'(opB[exp_w]) || nb != 4 + int'(opB[exp_w])) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got lat=%0d ldp=%0d busy=%0d exp B=%0d", n, td - tg, nl, nb, opB[exp_w]);
      end
      @(negedge clk);
      checks++;
      if (p_q !== exp_p || busy !== 1'b0) begin
        errors++; $display("FAIL rand_product[%0d]: got P=%0d busy=%b exp %0d/0", n, p_q, busy, exp_p);
      end
      m_ptr = (exp_w + 1) % NREQ;
    end
    req = '0;
  endtask

`ifdef MUL_TIMEOUT_EN
  task automatic test_timeout();
    logic [NREQ-1:0] g, d; int s, tg, td, nl, nb; logic e; bit ok;
    do_reset();
    opA[0] = 16'd1; opB[0] = 16'd50;
    hold_eqz0 = 1'b1;
    req = 4'b0001;
    observe_op(1'b1, g, s, tg, td, nl, nb, d, e, ok);
    checks++;
    if (!ok || nl != int'(MAX_ITER) || e !== 1'b1 || d !== 4'b0001 || td - tg != 2 + int'(MAX_ITER)) begin
      errors++;
      $display("FAIL timeout_op: got ok=%0d ldp=%0d err=%b done=%b lat=%0d exp 1/%0d/1/0001/%0d",
               ok, nl, e, d, td - tg, MAX_ITER, 2 + MAX_ITER);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got busy=%b err=%b exp 0/0", busy, err);
    end
    hold_eqz0 = 1'b0;
    m_ptr = 1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NREQ; i++) begin opA[i] = '0; opB[i] = '0; end
    test_reset();
    test_single();
    test_bzero();
    test_round_robin();
    test_priority();
    test_reset_mid_run();
    test_random();
`ifdef MUL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Round-robin scheduler that shares one repeated-addition multiplier datapath among NREQ requesters.
- Arbitrates among the requesters and drives the operand-select mux, so the datapath loads the winner's operands.
- Sequences the datapath's load, clear, accumulate and decrement controls until the datapath reports B==0 (eqz).
- Returns a per-requester done pulse. Sits between client blocks and the single multiplier datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SELW, 2, width of sel; must equal clog2(NREQ).
- MAX_ITER, 65535, RUN-cycle limit; used only with MUL_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  per-requester request level; operands are valid while high.
- gnt  output  NREQ  one-hot grant, held from LDA through DONE.
- sel  output  SELW  index of the granted requester; drives the datapath operand mux.
- ldA  output  1  load A register from the selected operand.
- ldB  output  1  load B register from the selected operand.
- clrP  output  1  clear product register.
- ldP  output  1  load P <= P + A.
- decB  output  1  B <= B - 1.
- eqz  input  1  datapath flag, combinational B==0 on the current B register.
- done  output  NREQ  one-cycle pulse to the granted requester.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle timeout pulse; tied 0 without MUL_TIMEOUT_EN.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE, ptr=0.
  - gnt, sel, done, err, busy all 0.
  - All datapath controls (ldA, ldB, clrP, ldP, decB) 0.
  - Datapath contents are not touched.
- States: IDLE, LDA, LDB, RUN, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit searching ptr, ptr+1, ... with wrap modulo NREQ.
  - Register gnt and sel for the winner; go to LDA.
  - If req==0, stay in IDLE.
- LDA: ldA=1 for one cycle; go to LDB.
- LDB: ldB=1 and clrP=1 for one cycle; go to RUN.
- RUN:
  - eqz=0: ldP=1 and decB=1 (Mealy); stay in RUN.
  - eqz=1: ldP=0 and decB=0; go to DONE.
- DONE:
  - done[sel]=1 for one cycle.
  - On exit: ptr=(sel+1) mod NREQ, gnt cleared; go to IDLE.
- All outputs except ldP and decB are Moore, decoded from the registered state. There are no #delays in the RTL.
- Latency, with grant registered at edge k and operand B=n:
  - LDA at k, LDB at k+1.
  - RUN spans k+2..k+2+n (n accumulate cycles plus one exit cycle).
  - DONE at k+3+n. busy is high for n+4 cycles.
  - Minimum gap between consecutive grants is one IDLE cycle.
- Arithmetic width, overflow and P output are owned by the datapath; this block only counts via eqz.
- Boundary conditions:
  - B=0: RUN lasts one cycle, ldP is never asserted, P=0.
  - req dropping mid-operation is ignored; the operation completes and done still pulses.
  - A requester must hold operands stable from grant until LDB completes. Operands are don't-care afterwards.
  - req still high in the IDLE cycle after its own DONE counts as a new request, at lowest priority because ptr has advanced.
  - Simultaneous requests are resolved only by the ptr order. No requester starves: worst-case wait is NREQ-1 operations.
  - An eqz glitch is not possible, because eqz is derived from registered B.

Optional Feature:
- Macro: MUL_TIMEOUT_EN.
- Defined: a counter clears on entry to RUN and increments on every RUN cycle with eqz=0.
  - If it reaches MAX_ITER with eqz still 0, go to DONE with err=1 in the DONE cycle.
  - done still pulses and ptr still advances.
- Undefined: no counter logic; err is constant 0; RUN exits only on eqz.

Test Plan:
- Single op: reset, then req=0001 with A=7, B=3. Expect gnt=0001 and sel=0; ldP/decB high for exactly 3 cycles; done=0001 at k+6; bench datapath P=21; busy high for 7 cycles.
- B=0: req=0100 with A=9, B=0. Expect ldP never high, done=0100 at k+3, P=0.
- Round robin: hold req=1111 continuously. Expect grant order 0,1,2,3,0,1 with exactly one IDLE cycle between DONE and the next LDA.
- Priority after service: after req0 is served, assert req=0011 together. Expect gnt=0010 first, then 0001.
- Reset mid-RUN: A=5, B=200; assert rst at the 10th RUN cycle. Expect all outputs 0 asynchronously, no done pulse, and after release req=1000 wins (ptr=0 scan finds bit 3).
- With MUL_TIMEOUT_EN and MAX_ITER=4: bench holds eqz=0. Expect 4 RUN cycles with ldP high, then err=1 and done pulse in the same cycle, then IDLE.
